// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache with single-line fill
// and saturating hit/miss counters.
module instruction_cache #(
   parameter int WORD_SIZE  = 16,
   parameter int LINE_WORDS = 4,
   parameter int NUM_LINES  = 8
) (
   input  logic                            clk,
   input  logic                            reset_n,
   input  logic                            invalidate,
   input  logic                            cpu_read,
   input  logic [WORD_SIZE-1:0]            cpu_address,
   output logic [WORD_SIZE-1:0]            cpu_data,
   output logic                            cpu_ready,
   output logic                            mem_read,
   output logic [WORD_SIZE-1:0]            mem_address,
   input  logic [LINE_WORDS*WORD_SIZE-1:0] mem_data,
   input  logic                            mem_ready,
   output logic [WORD_SIZE-1:0]            hit_count,
   output logic [WORD_SIZE-1:0]            miss_count
);

   localparam int OFF_BITS = $clog2(LINE_WORDS);
   localparam int IDX_BITS = $clog2(NUM_LINES);
   localparam int TAG_BITS = WORD_SIZE - OFF_BITS - IDX_BITS;

   typedef enum logic {IDLE, FILL} state_t;

   state_t state_q, state_d;

   logic [NUM_LINES-1:0]            valid_q, valid_d;
   logic [TAG_BITS-1:0]             tag_q  [NUM_LINES];
   logic [LINE_WORDS*WORD_SIZE-1:0] line_q [NUM_LINES];

   logic [IDX_BITS-1:0] fill_idx_q;
   logic [TAG_BITS-1:0] fill_tag_q;

   logic [OFF_BITS-1:0] off;
   logic [IDX_BITS-1:0] idx;
   logic [TAG_BITS-1:0] tag;
   logic                hit;
   logic                miss_go;
   logic                fill_done;

   assign off = cpu_address[OFF_BITS-1:0];
   assign idx = cpu_address[OFF_BITS +: IDX_BITS];
   assign tag = cpu_address[WORD_SIZE-1 -: TAG_BITS];

   assign hit = cpu_read && valid_q[idx] && (tag_q[idx] == tag);

   assign mem_address = {fill_tag_q, fill_idx_q, {OFF_BITS{1'b0}}};

   always_comb begin
      state_d   = state_q;
      cpu_ready = 1'b0;
      cpu_data  = '0;
      mem_read  = 1'b0;
      miss_go   = 1'b0;
      fill_done = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (hit) begin
               cpu_ready = 1'b1;
               cpu_data  = line_q[idx][int'(off)*WORD_SIZE +: WORD_SIZE];
            end else if (cpu_read) begin
               miss_go = 1'b1;
               state_d = FILL;
            end
         end
         FILL: begin
            mem_read = 1'b1;
            if (mem_ready) begin
               fill_done = 1'b1;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // A fill landing on an invalidate edge still leaves its own line valid.
   always_comb begin
      valid_d = valid_q;
      if (invalidate)
         valid_d = '0;
      if (fill_done)
         valid_d[fill_idx_q] = 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         valid_q    <= '0;
         fill_idx_q <= '0;
         fill_tag_q <= '0;
         hit_count  <= '0;
         miss_count <= '0;
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
         if (miss_go) begin
            fill_idx_q <= idx;
            fill_tag_q <= tag;
         end
         if (cpu_ready && !(&hit_count))
            hit_count <= hit_count + WORD_SIZE'(1);
         if (miss_go && !(&miss_count))
            miss_count <= miss_count + WORD_SIZE'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (fill_done) begin
         line_q[fill_idx_q] <= mem_data;
         tag_q[fill_idx_q]  <= fill_tag_q;
      end
   end

endmodule
